// File: rtl/serial_receiver_ovs.sv
// Oversampling serial receiver: start + DATA_W bits LSB-first (+ parity when SERIAL_RX_PARITY_EN) + stop, majority-voted.
// Strobes land two clocks after the stop-bit centre; no backpressure, each strobe lasts one cycle.
module serial_receiver_ovs #(
    parameter int DATA_W       = 8,
    parameter int OVS          = 3,
    parameter int TIMEOUT_CLKS = 28,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] byte_out,
    output logic              ready,
    output logic              frame_err,
    output logic              timeout,
    output logic              busy
);

    localparam int H     = OVS / 2;
    localparam int PH_W  = $clog2(OVS);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    if (DATA_W < 1 || DATA_W > 16 || OVS < 3 || TIMEOUT_CLKS < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("serial_receiver_ovs: parameter out of range");
    end

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              r_state, w_next;
    logic                r_sync1, r_rx_s, r_rx_p;
    logic [PH_W-1:0]     r_ph, w_ph;
    logic                r_s1, r_s2;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_shift, r_byte;
    logic                r_ready, r_ferr, r_timeout;
    logic [TO_W-1:0]     r_idle_cnt;
    logic                w_fall, w_vote_pt, w_vote, w_start_ok, w_stop_pt, w_par_bad;

    // Phase 0 is the cycle the falling edge is seen; samples sit at phases H-1, H, H+1.
    assign w_ph      = (r_state == S_IDLE) ? '0 : r_ph;
    assign w_fall    = (r_state == S_IDLE) && !r_rx_s && r_rx_p;
    assign w_vote_pt = (r_state != S_IDLE) && (r_ph == PH_W'(H + 1));
    assign w_vote    = (r_s1 & r_s2) | (r_s1 & r_rx_s) | (r_s2 & r_rx_s);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_stop_pt  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_vote_pt) begin
                         w_next     = w_vote ? S_IDLE : S_DATA;
                         w_start_ok = !w_vote;
                     end
            S_DATA:  if (w_vote_pt && r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                         w_next = S_PARITY;
`else
                         w_next = S_STOP;
`endif
                     end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: if (w_vote_pt) w_next = S_STOP;
`endif
            S_STOP:  if (w_vote_pt) begin
                         w_next    = S_IDLE;
                         w_stop_pt = 1'b1;
                     end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SERIAL_RX_PARITY_EN
    logic r_par_bad;
    always_ff @(posedge clk) begin
        if (rst || w_start_ok)
            r_par_bad <= 1'b0;
        else if (r_state == S_PARITY && w_vote_pt)
            r_par_bad <= w_vote != ((^r_shift) ^ PARITY_ODD[0]);
    end
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_p     <= 1'b1;
            r_ph       <= '0;
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_idx      <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_p  <= r_rx_s;

            if (r_state == S_IDLE)            r_ph <= w_fall ? PH_W'(1) : '0;
            else if (r_ph == PH_W'(OVS - 1))  r_ph <= '0;
            else                              r_ph <= r_ph + 1'b1;

            if (w_ph == PH_W'(H - 1)) r_s1 <= r_rx_s;
            if (w_ph == PH_W'(H))     r_s2 <= r_rx_s;

            if (w_start_ok) begin
                r_idx <= '0;
            end else if (r_state == S_DATA && w_vote_pt) begin
                r_shift[r_idx] <= w_vote;
                r_idx          <= r_idx + 1'b1;
            end

            r_ready <= w_stop_pt && w_vote && !w_par_bad;
            r_ferr  <= w_stop_pt && !(w_vote && !w_par_bad);
            if (w_stop_pt && w_vote && !w_par_bad) r_byte <= r_shift;

            // Idle counter runs in every state so a line that never drops still times out.
            if (!r_rx_s)                                  r_idle_cnt <= '0;
            else if (r_idle_cnt != TO_W'(TIMEOUT_CLKS))   r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_start_ok)                                            r_timeout <= 1'b0;
            else if (r_rx_s && r_idle_cnt >= TO_W'(TIMEOUT_CLKS - 1))  r_timeout <= 1'b1;
        end
    end

    assign byte_out  = r_byte;
    assign ready     = r_ready;
    assign frame_err = r_ferr;
    assign timeout   = r_timeout;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_receiver_ovs.sv
// Directed bench for serial_receiver_ovs at DATA_W=8, OVS=3, TIMEOUT_CLKS=28.
module tb_serial_receiver_ovs;

    localparam int DW    = 8;
    localparam int OVS   = 3;
    localparam int H     = OVS / 2;
    localparam int TMO   = 28;
    localparam int P_ODD = 0;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Drive cycle of start bit -> strobe cycle: 2 sync clocks, centre offset, stop index, vote+register.
    localparam int LAT = 2 + H + (DW + 1 + NPAR) * OVS + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [DW-1:0] byte_out;
    logic          ready, frame_err, timeout, busy;

    serial_receiver_ovs #(
        .DATA_W(DW), .OVS(OVS), .TIMEOUT_CLKS(TMO), .PARITY_ODD(P_ODD)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .byte_out(byte_out),
        .ready(ready), .frame_err(frame_err), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            rdy_cyc_q[$];
    logic [DW-1:0] rdy_byte_q[$];
    int            err_cyc_q[$];

    always @(negedge clk) begin
        if (ready) begin
            rdy_cyc_q.push_back(cyc);
            rdy_byte_q.push_back(byte_out);
        end
        if (frame_err) err_cyc_q.push_back(cyc);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rdy_cyc_q.delete();
        rdy_byte_q.delete();
        err_cyc_q.delete();
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(OVS);
    endtask

    // gl >= 0 inverts data bit gl for one clock at its centre.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int gl,
                              input logic pflip, output int s);
        s = cyc;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (i == gl) begin
                rx = d[i];  tick(H);
                rx = ~d[i]; tick(1);
                rx = d[i];  tick(OVS - H - 1);
            end else begin
                send_bit(d[i]);
            end
        end
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ P_ODD[0] ^ pflip);
`else
        if (pflip) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          stop;
        int            gl;
        int            exp_rdy;
        int            exp_err;
        logic [DW-1:0] exp_byte;
    } vec_t;

    vec_t tbl[6];
    int   s, s2;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5};
        tbl[1] = '{8'h55, 1'b0, -1, 0, 1, 8'hA5};
        tbl[2] = '{8'h12, 1'b1, -1, 1, 0, 8'h12};
        tbl[3] = '{8'h00, 1'b1,  3, 1, 0, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, -1, 1, 0, 8'hFF};
        tbl[5] = '{8'h80, 1'b1,  7, 1, 0, 8'h80};

        // Reset values, then the idle timeout from a quiet line.
        tick(3);
        @(negedge clk);
        check("rst_byte_out", byte_out, 0);
        check("rst_ready", ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        tick(1);
        rst = 1'b0;
        repeat (27) @(posedge clk);
        @(negedge clk);
        check("timeout_at_27", timeout, 0);
        @(negedge clk);
        check("timeout_at_28", timeout, 1);

        for (int v = 0; v < 6; v++) begin
            clear_q();
            tick(1);
            send_frame(tbl[v].d, tbl[v].stop, tbl[v].gl, 1'b0, s);
            rx = 1'b1;
            tick(6);
            @(negedge clk);
            check($sformatf("v%0d_ready_cnt", v), rdy_cyc_q.size(), tbl[v].exp_rdy);
            check($sformatf("v%0d_err_cnt", v), err_cyc_q.size(), tbl[v].exp_err);
            check($sformatf("v%0d_byte_out", v), byte_out, tbl[v].exp_byte);
            if (rdy_cyc_q.size() > 0) check($sformatf("v%0d_ready_lat", v), rdy_cyc_q[0] - s, LAT);
            if (err_cyc_q.size() > 0) check($sformatf("v%0d_err_lat", v), err_cyc_q[0] - s, LAT);
            if (v == 0) check("timeout_cleared_by_start", timeout, 0);
        end

        // Back-to-back frames with a stop bit of exactly OVS clocks.
        clear_q();
        tick(1);
        send_frame(8'h3C, 1'b1, -1, 1'b0, s);
        send_frame(8'hC3, 1'b1, -1, 1'b0, s2);
        tick(6);
        @(negedge clk);
        check("b2b_ready_cnt", rdy_cyc_q.size(), 2);
        if (rdy_cyc_q.size() == 2) begin
            check("b2b_byte0", rdy_byte_q[0], 8'h3C);
            check("b2b_byte1", rdy_byte_q[1], 8'hC3);
            check("b2b_spacing", rdy_cyc_q[1] - rdy_cyc_q[0], (DW + 2 + NPAR) * OVS);
            check("b2b_lat0", rdy_cyc_q[0] - s, LAT);
        end
        check("b2b_err_cnt", err_cyc_q.size(), 0);

        // One-clock start glitch.
        clear_q();
        tick(1);
        s = cyc;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        @(negedge clk);
        check("glitch_busy_high", busy, 1);
        tick(2);
        @(negedge clk);
        check("glitch_busy_dropped", busy, 0);
        tick(10);
        @(negedge clk);
        check("glitch_ready_cnt", rdy_cyc_q.size(), 0);
        check("glitch_err_cnt", err_cyc_q.size(), 0);
        check("glitch_byte_out", byte_out, 8'hC3);

        // Break: line held low through and beyond the stop bit.
        clear_q();
        tick(1);
        send_frame(8'h00, 1'b0, -1, 1'b0, s);
        tick(20);
        @(negedge clk);
        check("break_err_cnt", err_cyc_q.size(), 1);
        check("break_ready_cnt", rdy_cyc_q.size(), 0);
        check("break_busy", busy, 0);
        check("break_byte_out", byte_out, 8'hC3);
        if (err_cyc_q.size() > 0) check("break_err_lat", err_cyc_q[0] - s, LAT);
        check("break_timeout_low", timeout, 0);
        tick(1);
        rx = 1'b1;
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("break_timeout_at_27", timeout, 0);
        @(negedge clk);
        check("break_timeout_at_28", timeout, 1);

`ifdef SERIAL_RX_PARITY_EN
        clear_q();
        tick(1);
        send_frame(8'h07, 1'b1, -1, 1'b1, s);
        rx = 1'b1;
        tick(6);
        @(negedge clk);
        check("par_bad_err_cnt", err_cyc_q.size(), 1);
        check("par_bad_ready_cnt", rdy_cyc_q.size(), 0);
        check("par_bad_byte_out", byte_out, 8'hC3);
        if (err_cyc_q.size() > 0) check("par_bad_err_lat", err_cyc_q[0] - s, LAT);
        clear_q();
        tick(1);
        send_frame(8'h07, 1'b1, -1, 1'b0, s);
        rx = 1'b1;
        tick(6);
        @(negedge clk);
        check("par_ok_ready_cnt", rdy_cyc_q.size(), 1);
        check("par_ok_err_cnt", err_cyc_q.size(), 0);
        check("par_ok_byte_out", byte_out, 8'h07);
`endif

        // Reset in the middle of a frame discards it.
        clear_q();
        tick(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        check("midrst_busy_before", busy, 1);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rx  = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst_busy_after", busy, 0);
        check("midrst_byte_out", byte_out, 0);
        tick(40);
        @(negedge clk);
        check("midrst_ready_cnt", rdy_cyc_q.size(), 0);
        check("midrst_err_cnt", err_cyc_q.size(), 0);

        clear_q();
        tick(1);
        send_frame(8'h12, 1'b1, -1, 1'b0, s);
        rx = 1'b1;
        tick(6);
        @(negedge clk);
        check("post_rst_ready_cnt", rdy_cyc_q.size(), 1);
        check("post_rst_byte_out", byte_out, 8'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
